// File: rtl/pcie_dllp_rx.sv
// pcie_dllp_rx -- receive-side DLLP decoder for the PCIe data link layer.
//
// Accepts one 6-byte DLLP per cycle and checks its CRC16. Ack/Nak DLLPs have
// their sequence numbers checked against the transmit window. The decoder
// tracks AckD_SEQ and runs the far-end flow-control init FSM that loads the
// credit limits. Every output is registered and updates one cycle after the
// DLLP is presented.
//
// Ports
//   clk            clock
//   rst_n          synchronous reset, active low
//   link_up_i      0 = DL_Inactive, all state forced to reset values
//   dllp_valid_i   a DLLP is present on dllp_i this cycle
//   dllp_i         [7:0] type, [31:8] payload bytes 1..3, [47:32] CRC bytes 4..5
//   next_tx_seq_i  NEXT_TRANSMIT_SEQ from the transmit side
//   ack_o, nak_o   single-cycle pulse for an accepted Ack / Nak
//   acknak_seq_o   sequence number of the Ack/Nak pulsed this cycle
//   ackd_seq_o     AckD_SEQ
//   fc_state_o     0 IDLE, 1 INIT1, 2 INIT2, 3 DONE
//   ph/nph/cplh_o  header credit limits for P / NP / Cpl
//   pd/npd/cpld_o  data credit limits for P / NP / Cpl
//   crc_err_o      pulse: CRC mismatch, DLLP dropped
//   seq_err_o      pulse: Ack/Nak sequence outside the window, DLLP dropped
//   unsup_o        pulse: good CRC but unknown type or foreign VC, DLLP dropped
module pcie_dllp_rx #(
    parameter logic [2:0]  VC_ID      = 3'd0,
    parameter int unsigned SEQ_WINDOW = 32'd2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_up_i,
    input  logic        dllp_valid_i,
    input  logic [47:0] dllp_i,
    input  logic [11:0] next_tx_seq_i,
    output logic        ack_o,
    output logic        nak_o,
    output logic [11:0] acknak_seq_o,
    output logic [11:0] ackd_seq_o,
    output logic [1:0]  fc_state_o,
    output logic [7:0]  ph_o,
    output logic [7:0]  nph_o,
    output logic [7:0]  cplh_o,
    output logic [11:0] pd_o,
    output logic [11:0] npd_o,
    output logic [11:0] cpld_o,
    output logic        crc_err_o,
    output logic        seq_err_o,
    output logic        unsup_o
);

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_INIT1 = 2'd1,
        FC_INIT2 = 2'd2,
        FC_DONE  = 2'd3
    } fc_state_t;

    // CRC16 over DLLP bytes 0..3, byte 0 bit 0 shifted in first. The
    // remainder is inverted and bit-reversed within each CRC byte:
    // byte 4 carries remainder bits 8..15 (bit 7 = remainder bit 8),
    // byte 5 carries remainder bits 0..7  (bit 7 = remainder bit 0).
    function automatic logic [15:0] dllp_crc16(input logic [31:0] data_i);
        logic [15:0] lfsr;
        logic [15:0] mapped;
        logic        fb;
        lfsr   = 16'hFFFF;
        mapped = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            fb   = lfsr[15] ^ data_i[i];
            lfsr = {lfsr[14:0], 1'b0};
            if (fb) begin
                lfsr = lfsr ^ 16'h100B;
            end else begin
                lfsr = lfsr;
            end
        end
        for (int i = 0; i < 8; i++) begin
            mapped[7 - i]  = ~lfsr[8 + i];
            mapped[15 - i] = ~lfsr[i];
        end
        return mapped;
    endfunction

    fc_state_t   state_q, state_d;
    logic [2:0]  flags_q, flags_d;
    logic [11:0] ackd_q, ackd_d;
    logic [11:0] acknak_seq_q, acknak_seq_d;
    logic        ack_q, ack_d, nak_q, nak_d;
    logic        crc_err_q, crc_err_d, seq_err_q, seq_err_d, unsup_q, unsup_d;
    logic [7:0]  ph_q, ph_d, nph_q, nph_d, cplh_q, cplh_d;
    logic [11:0] pd_q, pd_d, npd_q, npd_d, cpld_q, cpld_d;

    logic [7:0]  type_s;
    logic        crc_ok_s;
    logic        is_ack_s, is_nak_s, is_fc_s;
    logic        is_init1_s, is_init2_s, is_update_s;
    logic [1:0]  fc_sel_s;
    logic [11:0] seq_s, dist_s;
    logic        in_win_s;
    logic [7:0]  hdr_s;
    logic [11:0] data_s;
    logic        load_s;
    logic        unused_scale_bits_s;

    assign type_s   = dllp_i[7:0];
    assign seq_s    = {dllp_i[19:16], dllp_i[31:24]};
    assign hdr_s    = {dllp_i[13:8], dllp_i[23:22]};
    assign data_s   = {dllp_i[19:16], dllp_i[31:24]};
    assign fc_sel_s = type_s[5:4];
    // Scale fields are not supported; only unscaled credits are decoded.
    assign unused_scale_bits_s = ^{dllp_i[15:14], dllp_i[21:20]};

    // Combinational DLLP classification and sequence-window check.
    always_comb begin
        crc_ok_s    = (dllp_i[47:32] == dllp_crc16(dllp_i[31:0]));
        is_ack_s    = (type_s == 8'h00);
        is_nak_s    = (type_s == 8'h10);
        // FC types: [7:6] selects InitFC1/UpdateFC/InitFC2, [5:4] selects
        // P/NP/Cpl, [3] must be zero and [2:0] is the VC.
        is_fc_s     = (type_s[7:6] != 2'b00) && (fc_sel_s != 2'b11) &&
                      (type_s[3] == 1'b0) && (type_s[2:0] == VC_ID);
        is_init1_s  = is_fc_s && (type_s[7:6] == 2'b01);
        is_update_s = is_fc_s && (type_s[7:6] == 2'b10);
        is_init2_s  = is_fc_s && (type_s[7:6] == 2'b11);
        dist_s      = next_tx_seq_i - 12'd1 - seq_s;
        in_win_s    = ({20'd0, dist_s} < SEQ_WINDOW);
    end

    // Next-state for the FC FSM, AckD_SEQ, pulses and credit limits.
    always_comb begin
        state_d      = state_q;
        flags_d      = flags_q;
        ackd_d       = ackd_q;
        acknak_seq_d = acknak_seq_q;
        ack_d        = 1'b0;
        nak_d        = 1'b0;
        crc_err_d    = 1'b0;
        seq_err_d    = 1'b0;
        unsup_d      = 1'b0;
        ph_d         = ph_q;
        nph_d        = nph_q;
        cplh_d       = cplh_q;
        pd_d         = pd_q;
        npd_d        = npd_q;
        cpld_d       = cpld_q;
        load_s       = 1'b0;

        if (!link_up_i) begin
            state_d      = FC_IDLE;
            flags_d      = 3'b000;
            ackd_d       = 12'hFFF;
            acknak_seq_d = 12'h000;
            ph_d         = 8'h00;
            nph_d        = 8'h00;
            cplh_d       = 8'h00;
            pd_d         = 12'h000;
            npd_d        = 12'h000;
            cpld_d       = 12'h000;
        end else begin
            if (state_q == FC_IDLE) begin
                state_d = FC_INIT1;
            end else begin
                state_d = state_q;
            end

            if (!dllp_valid_i) begin
                load_s = 1'b0;
            end else if (!crc_ok_s) begin
                crc_err_d = 1'b1;
            end else if (is_ack_s || is_nak_s) begin
                if (in_win_s) begin
                    ack_d        = is_ack_s;
                    nak_d        = is_nak_s;
                    acknak_seq_d = seq_s;
                    ackd_d       = seq_s;
                end else begin
                    seq_err_d = 1'b1;
                end
            end else if (is_fc_s) begin
                // Accepted FC DLLPs never pulse; out-of-phase ones are silently ignored.
                case (state_q)
                    FC_INIT1: begin
                        if (is_init1_s || is_init2_s) begin
                            load_s = 1'b1;
                            case (fc_sel_s)
                                2'd0:    flags_d[0] = 1'b1;
                                2'd1:    flags_d[1] = 1'b1;
                                2'd2:    flags_d[2] = 1'b1;
                                default: flags_d    = flags_q;
                            endcase
                        end else begin
                            load_s = 1'b0;
                        end
                    end
                    FC_INIT2: begin
                        load_s = is_update_s;
                        if (is_init2_s || is_update_s) begin
                            state_d = FC_DONE;
                        end else begin
                            state_d = FC_INIT2;
                        end
                    end
                    FC_DONE: begin
                        load_s = is_update_s;
                    end
                    default: begin
                        load_s = 1'b0;
                    end
                endcase
            end else begin
                unsup_d = 1'b1;
            end

            // The last InitFC of INIT1 moves to INIT2 on the same edge it loads.
            if ((state_q == FC_INIT1) && (&flags_d)) begin
                state_d = FC_INIT2;
            end else begin
                state_d = state_d;
            end

            if (load_s) begin
                case (fc_sel_s)
                    2'd0: begin
                        ph_d = hdr_s;
                        pd_d = data_s;
                    end
                    2'd1: begin
                        nph_d = hdr_s;
                        npd_d = data_s;
                    end
                    2'd2: begin
                        cplh_d = hdr_s;
                        cpld_d = data_s;
                    end
                    default: begin
                        ph_d = ph_q;
                    end
                endcase
            end else begin
                ph_d = ph_d;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FC_IDLE;
            flags_q      <= 3'b000;
            ackd_q       <= 12'hFFF;
            acknak_seq_q <= 12'h000;
            ack_q        <= 1'b0;
            nak_q        <= 1'b0;
            crc_err_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            unsup_q      <= 1'b0;
            ph_q         <= 8'h00;
            nph_q        <= 8'h00;
            cplh_q       <= 8'h00;
            pd_q         <= 12'h000;
            npd_q        <= 12'h000;
            cpld_q       <= 12'h000;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            ackd_q       <= ackd_d;
            acknak_seq_q <= acknak_seq_d;
            ack_q        <= ack_d;
            nak_q        <= nak_d;
            crc_err_q    <= crc_err_d;
            seq_err_q    <= seq_err_d;
            unsup_q      <= unsup_d;
            ph_q         <= ph_d;
            nph_q        <= nph_d;
            cplh_q       <= cplh_d;
            pd_q         <= pd_d;
            npd_q        <= npd_d;
            cpld_q       <= cpld_d;
        end
    end

    assign ack_o        = ack_q;
    assign nak_o        = nak_q;
    assign acknak_seq_o = acknak_seq_q;
    assign ackd_seq_o   = ackd_q;
    assign fc_state_o   = state_q;
    assign ph_o         = ph_q;
    assign nph_o        = nph_q;
    assign cplh_o       = cplh_q;
    assign pd_o         = pd_q;
    assign npd_o        = npd_q;
    assign cpld_o       = cpld_q;
    assign crc_err_o    = crc_err_q;
    assign seq_err_o    = seq_err_q;
    assign unsup_o      = unsup_q;

endmodule

// File: tb/tb_pcie_dllp_rx.sv
// Testbench for pcie_dllp_rx: directed DLLPs; expected pulses are queued at
// issue time and checked by an independent monitor; register state is checked
// directly against hand-computed constants.
module tb_pcie_dllp_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        link_up;
    logic        dllp_valid;
    logic [47:0] dllp;
    logic [11:0] next_tx_seq;
    logic        ack, nak, crc_err, seq_err, unsup;
    logic [11:0] acknak_seq, ackd_seq;
    logic [1:0]  fc_state;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_ACK  = 5'b10000;
    localparam logic [4:0] K_NAK  = 5'b01000;
    localparam logic [4:0] K_CRC  = 5'b00100;
    localparam logic [4:0] K_SEQ  = 5'b00010;
    localparam logic [4:0] K_UNS  = 5'b00001;

    typedef struct {
        int          cyc;
        logic [4:0]  k;
        logic [11:0] seq;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    pcie_dllp_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link_up_i    (link_up),
        .dllp_valid_i (dllp_valid),
        .dllp_i       (dllp),
        .next_tx_seq_i(next_tx_seq),
        .ack_o        (ack),
        .nak_o        (nak),
        .acknak_seq_o (acknak_seq),
        .ackd_seq_o   (ackd_seq),
        .fc_state_o   (fc_state),
        .ph_o         (ph),
        .nph_o        (nph),
        .cplh_o       (cplh),
        .pd_o         (pd),
        .npd_o        (npd),
        .cpld_o       (cpld),
        .crc_err_o    (crc_err),
        .seq_err_o    (seq_err),
        .unsup_o      (unsup)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference CRC: shift register with the 100B taps written out explicitly.
    function automatic logic [15:0] ref_crc(input logic [31:0] m);
        logic [15:0] c;
        logic [15:0] inv;
        logic [7:0]  b4, b5;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                fb    = c[15] ^ m[8*k + j];
                c     = c << 1;
                c[0]  = fb;
                c[1]  = c[1] ^ fb;
                c[3]  = c[3] ^ fb;
                c[12] = c[12] ^ fb;
            end
        end
        inv = ~c;
        for (int j = 0; j < 8; j++) begin
            b4[j] = inv[15 - j];
            b5[j] = inv[7 - j];
        end
        return {b5, b4};
    endfunction

    function automatic logic [23:0] pl_seq(input logic [11:0] s);
        return {s[7:0], 4'h0, s[11:8], 8'h00};
    endfunction

    function automatic logic [23:0] pl_fc(input logic [7:0] h, input logic [11:0] d);
        return {d[7:0], h[1:0], 2'b00, d[11:8], 2'b00, h[7:2]};
    endfunction

    task automatic send(input logic [7:0] t, input logic [23:0] pl,
                        input logic [4:0] k, input logic [11:0] s, input bit flip);
        exp_t x;
        @(posedge clk);
        #1;
        dllp_valid = 1'b1;
        dllp       = {ref_crc({pl, t}), pl, t};
        if (flip) dllp[32] = ~dllp[32];
        if (k != K_NONE) begin
            x.cyc = cyc + 1;
            x.k   = k;
            x.seq = s;
            exp_q.push_back(x);
        end
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
        dllp_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [4:0] v;
        v = {ack, nak, crc_err, seq_err, unsup};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_pulse cyc=%0d want_kind=%b", exp_q[0].cyc, exp_q[0].k);
            void'(exp_q.pop_front());
        end
        if (v != K_NONE) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d kind=%b", cyc, v);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.k != v ||
                    ((v == K_ACK || v == K_NAK) && acknak_seq != e.seq)) begin
                    bad++;
                    $display("FAIL pulse cyc=%0d kind=%b seq=%0h want cyc=%0d kind=%b seq=%0h",
                             cyc, v, acknak_seq, e.cyc, e.k, e.seq);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        link_up     = 1'b1;
        dllp_valid  = 1'b0;
        dllp        = 48'h0;
        next_tx_seq = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ackd", 32'(ackd_seq), 32'h FFF);
        chk("rst_state", 32'(fc_state), 32'd0);
        chk("rst_ph", 32'(ph), 32'h0);
        chk("rst_pd", 32'(pd), 32'h0);
        rst_n = 1'b1;
        gap();
        chk("idle_to_init1", 32'(fc_state), 32'd1);

        // 1: FC init
        send(8'h40, pl_fc(8'h20, 12'h100), K_NONE, 12'h0, 1'b0);
        send(8'h50, pl_fc(8'h01, 12'h000), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t1_state_init1", 32'(fc_state), 32'd1);
        chk("t1_ph", 32'(ph), 32'h20);
        chk("t1_pd", 32'(pd), 32'h100);
        chk("t1_nph", 32'(nph), 32'h01);
        send(8'h60, pl_fc(8'h00, 12'h000), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t1_state_init2", 32'(fc_state), 32'd2);
        send(8'h80, pl_fc(8'h28, 12'h140), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t1_state_done", 32'(fc_state), 32'd3);
        chk("t1_ph_upd", 32'(ph), 32'h28);
        chk("t1_pd_upd", 32'(pd), 32'h140);

        // 2: Ack window
        next_tx_seq = 12'h010;
        send(8'h00, pl_seq(12'h00F), K_ACK, 12'h00F, 1'b0);
        gap();
        chk("t2_ackd", 32'(ackd_seq), 32'h00F);
        send(8'h00, pl_seq(12'h80F), K_SEQ, 12'h0, 1'b0);
        gap();
        chk("t2_ackd_seqerr", 32'(ackd_seq), 32'h00F);

        // 3: CRC error
        send(8'h00, pl_seq(12'h005), K_CRC, 12'h0, 1'b1);
        gap();
        chk("t3_ackd_crc", 32'(ackd_seq), 32'h00F);

        // 4: wrap
        next_tx_seq = 12'h002;
        send(8'h00, pl_seq(12'hFFF), K_ACK, 12'hFFF, 1'b0);
        gap();
        chk("t4_ackd_wrap", 32'(ackd_seq), 32'hFFF);
        send(8'h10, pl_seq(12'hFFF), K_NAK, 12'hFFF, 1'b0);
        send(8'h10, pl_seq(12'h000), K_NAK, 12'h000, 1'b0);
        gap();
        chk("t4_ackd_nak", 32'(ackd_seq), 32'h000);
        send(8'h00, pl_seq(12'h002), K_SEQ, 12'h0, 1'b0);
        gap();
        chk("t4_ackd_future", 32'(ackd_seq), 32'h000);

        // 5: unsupported / ignored in DONE
        send(8'h41, pl_fc(8'h33, 12'h333), K_UNS, 12'h0, 1'b0);
        send(8'h20, 24'h000000, K_UNS, 12'h0, 1'b0);
        send(8'h40, pl_fc(8'h55, 12'h555), K_NONE, 12'h0, 1'b0);
        send(8'h90, pl_fc(8'h11, 12'h222), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t5_ph_hold", 32'(ph), 32'h28);
        chk("t5_pd_hold", 32'(pd), 32'h140);
        chk("t5_nph_upd", 32'(nph), 32'h11);
        chk("t5_npd_upd", 32'(npd), 32'h222);
        chk("t5_state", 32'(fc_state), 32'd3);

        // 6: link drop mid-init, then back-to-back traffic
        @(posedge clk);
        #1;
        link_up = 1'b0;
        gap();
        chk("t6_down_state", 32'(fc_state), 32'd0);
        link_up = 1'b1;
        gap();
        chk("t6_up_state", 32'(fc_state), 32'd1);
        send(8'h40, pl_fc(8'h10, 12'h010), K_NONE, 12'h0, 1'b0);
        send(8'hD0, pl_fc(8'h02, 12'h020), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t6_two_flags_state", 32'(fc_state), 32'd1);
        chk("t6_ph", 32'(ph), 32'h10);
        chk("t6_nph_init2type", 32'(nph), 32'h02);
        @(posedge clk);
        #1;
        link_up = 1'b0;
        gap();
        chk("t6_drop_state", 32'(fc_state), 32'd0);
        chk("t6_drop_ackd", 32'(ackd_seq), 32'hFFF);
        chk("t6_drop_ph", 32'(ph), 32'h0);
        chk("t6_drop_npd", 32'(npd), 32'h0);
        link_up = 1'b1;
        gap();
        send(8'h40, pl_fc(8'h01, 12'h001), K_NONE, 12'h0, 1'b0);
        send(8'h50, pl_fc(8'h02, 12'h002), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t6_flags_cleared", 32'(fc_state), 32'd1);
        send(8'h60, pl_fc(8'h03, 12'h003), K_NONE, 12'h0, 1'b0);
        gap();
        chk("t6_reinit2", 32'(fc_state), 32'd2);
        next_tx_seq = 12'h010;
        send(8'h00, pl_seq(12'h000), K_ACK, 12'h000, 1'b0);
        send(8'hA0, pl_fc(8'h04, 12'h044), K_NONE, 12'h0, 1'b0);
        send(8'h00, pl_seq(12'h001), K_ACK, 12'h001, 1'b0);
        send(8'h80, pl_fc(8'h05, 12'h055), K_NONE, 12'h0, 1'b0);
        send(8'h10, pl_seq(12'h002), K_NAK, 12'h002, 1'b0);
        send(8'h00, pl_seq(12'h003), K_ACK, 12'h003, 1'b0);
        gap();
        chk("t6_b2b_state", 32'(fc_state), 32'd3);
        chk("t6_b2b_cplh", 32'(cplh), 32'h04);
        chk("t6_b2b_cpld", 32'(cpld), 32'h044);
        chk("t6_b2b_ph", 32'(ph), 32'h05);
        chk("t6_b2b_pd", 32'(pd), 32'h055);
        chk("t6_b2b_ackd", 32'(ackd_seq), 32'h003);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
